// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus sequencer: FSM states,
// requester indices and the fixed arbitration order.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_DONE
  } bus_state_e;

  localparam int N_REQ = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_WI = 2'd0;
  localparam sel_t SEL_WF = 2'd1;
  localparam sel_t SEL_I  = 2'd2;
  localparam sel_t SEL_WR = 2'd3;

  // Highest priority first.
  localparam sel_t PRIO_ORDER [N_REQ] = '{SEL_WI, SEL_WF, SEL_WR, SEL_I};

  // Scan from lowest to highest priority so the highest asserted one wins.
  function automatic sel_t pick_winner(input logic [N_REQ-1:0] req);
    sel_t win;
    win = PRIO_ORDER[0];
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[PRIO_ORDER[k]]) win = PRIO_ORDER[k];
    end
    return win;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Down-counter that measures one bus phase: loaded with (length-1) on entry
// to a phase, it flags the last cycle of that phase.
module bus_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Arbitrates the RTC parallel bus among four requesters and generates the
// multiplexed address/data strobe sequence, capturing the byte on reads.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 6,
  parameter int T_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] rw,
  input  logic [7:0] bus_in,
  output logic [3:0] grant,
  output logic [1:0] data_sel,
  output logic       addr_phase,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rd_data,
  output logic       done
);

  localparam int CW = $clog2(max3(T_SETUP, T_PULSE, T_HOLD)) + 1;
  localparam logic [CW-1:0] SETUP_M1 = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_M1 = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(T_HOLD - 1);

  bus_state_e    r_state, w_next;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_last;
  sel_t          w_win;

  logic [3:0] r_grant;
  sel_t       r_sel;
  logic       r_rw;
  logic [7:0] r_rd_data;

  logic r_addr_phase, r_bus_oe, r_cs_n, r_ad_n, r_wr_n, r_rd_n, r_done;
  logic w_addr_phase, w_bus_oe, w_cs_n, w_ad_n, w_wr_n, w_rd_n, w_done;

  assign w_win = pick_winner(req);

  bus_phase_timer #(.W(CW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: if (|req) begin
        w_next = ST_A_SETUP; w_load = 1'b1; w_load_val = SETUP_M1;
      end
      ST_A_SETUP: if (w_last) begin
        w_next = ST_A_PULSE; w_load = 1'b1; w_load_val = PULSE_M1;
      end
      ST_A_PULSE: if (w_last) begin
        w_next = ST_A_HOLD;  w_load = 1'b1; w_load_val = HOLD_M1;
      end
      ST_A_HOLD: if (w_last) begin
        w_next = ST_D_SETUP; w_load = 1'b1; w_load_val = SETUP_M1;
      end
      ST_D_SETUP: if (w_last) begin
        w_next = ST_D_PULSE; w_load = 1'b1; w_load_val = PULSE_M1;
      end
      ST_D_PULSE: if (w_last) begin
        w_next = ST_D_HOLD;  w_load = 1'b1; w_load_val = HOLD_M1;
      end
      ST_D_HOLD: if (w_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and then registered, so the pads
  // see glitch-free levels that change exactly on the state edges.
  always_comb begin
    w_addr_phase = 1'b0;
    w_bus_oe     = 1'b0;
    w_cs_n       = 1'b1;
    w_ad_n       = 1'b1;
    w_wr_n       = 1'b1;
    w_rd_n       = 1'b1;
    w_done       = 1'b0;
    case (w_next)
      ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
        w_addr_phase = 1'b1;
        w_bus_oe     = 1'b1;
        w_cs_n       = 1'b0;
        w_ad_n       = 1'b0;
        w_wr_n       = (w_next != ST_A_PULSE);
      end
      ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
        w_cs_n   = 1'b0;
        w_bus_oe = ~r_rw;
        if (w_next == ST_D_PULSE) begin
          w_wr_n = r_rw;
          w_rd_n = ~r_rw;
        end
      end
      ST_DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_phase <= 1'b0;
      r_bus_oe     <= 1'b0;
      r_cs_n       <= 1'b1;
      r_ad_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_rd_n       <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_addr_phase <= w_addr_phase;
      r_bus_oe     <= w_bus_oe;
      r_cs_n       <= w_cs_n;
      r_ad_n       <= w_ad_n;
      r_wr_n       <= w_wr_n;
      r_rd_n       <= w_rd_n;
      r_done       <= w_done;
    end
  end

  // Grant, select and direction are frozen for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant <= '0;
      r_sel   <= SEL_WI;
      r_rw    <= 1'b0;
    end else if (r_state == ST_IDLE && |req) begin
      r_grant <= 4'b0001 << w_win;
      r_sel   <= w_win;
      r_rw    <= rw[w_win];
    end else if (r_state == ST_DONE) begin
      r_grant <= '0;
    end
  end

  // Capture on the edge that ends the read pulse, where rd_n returns high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (r_state == ST_D_PULSE && w_last && r_rw) begin
      r_rd_data <= bus_in;
    end
  end

  assign grant      = r_grant;
  assign data_sel   = r_sel;
  assign addr_phase = r_addr_phase;
  assign bus_oe     = r_bus_oe;
  assign cs_n       = r_cs_n;
  assign ad_n       = r_ad_n;
  assign wr_n       = r_wr_n;
  assign rd_n       = r_rd_n;
  assign rd_data    = r_rd_data;
  assign done       = r_done;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench: a default-timing instance and a 1/1/1-timing instance
// are driven with directed and random requests against a per-cycle model.
module tb_rtc_bus_sequencer;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] data_sel;
    logic       addr_phase;
    logic       bus_oe;
    logic       cs_n;
    logic       ad_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] rd_data;
    logic       done;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel_dut;
  logic [3:0] req_v, rw_v, req0, req1;
  logic [7:0] bus_in;
  obs_t       o0, o1, ob;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_rd;
  logic       prev_cs, prev_ad, prev_wr, prev_rd;

  always #5 clk = ~clk;

  assign req0 = sel_dut ? 4'b0000 : req_v;
  assign req1 = sel_dut ? req_v : 4'b0000;
  assign ob   = sel_dut ? o1 : o0;

  rtc_bus_sequencer dut0 (
    .clk(clk), .reset(reset), .req(req0), .rw(rw_v), .bus_in(bus_in),
    .grant(o0.grant), .data_sel(o0.data_sel), .addr_phase(o0.addr_phase),
    .bus_oe(o0.bus_oe), .cs_n(o0.cs_n), .ad_n(o0.ad_n), .wr_n(o0.wr_n),
    .rd_n(o0.rd_n), .rd_data(o0.rd_data), .done(o0.done)
  );

  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .rw(rw_v), .bus_in(bus_in),
    .grant(o1.grant), .data_sel(o1.data_sel), .addr_phase(o1.addr_phase),
    .bus_oe(o1.bus_oe), .cs_n(o1.cs_n), .ad_n(o1.ad_n), .wr_n(o1.wr_n),
    .rd_n(o1.rd_n), .rd_data(o1.rd_data), .done(o1.done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fixed priority WI > WF > WR > I, written straight from the bit meanings.
  function automatic logic [1:0] model_pick(input logic [3:0] r);
    if (r[0]) return 2'd0;
    if (r[1]) return 2'd1;
    if (r[3]) return 2'd3;
    return 2'd2;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, ".grant"},    8'(ob.grant),    8'h00);
    check({tag, ".data_sel"}, 8'(ob.data_sel), 8'h00);
    check({tag, ".addr"},     8'(ob.addr_phase), 8'h00);
    check({tag, ".bus_oe"},   8'(ob.bus_oe),   8'h00);
    check({tag, ".cs_n"},     8'(ob.cs_n),     8'h01);
    check({tag, ".ad_n"},     8'(ob.ad_n),     8'h01);
    check({tag, ".wr_n"},     8'(ob.wr_n),     8'h01);
    check({tag, ".rd_n"},     8'(ob.rd_n),     8'h01);
    check({tag, ".rd_data"},  ob.rd_data,      8'h00);
    check({tag, ".done"},     8'(ob.done),     8'h00);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    @(negedge clk);
    reset   = 1'b0;
    exp_rd  = 8'h00;
    prev_cs = 1'b1; prev_ad = 1'b1; prev_wr = 1'b1; prev_rd = 1'b1;
  endtask

  // Call at a negedge with the DUT idle and req_v non-zero. Checks every cycle
  // from the first A_SETUP through the IDLE cycle after DONE. The winner drops
  // its request at DONE; mid_c/mid_req override req_v during the transaction;
  // fixed >= 0 drives that byte on bus_in during the data pulse.
  task automatic run_txn(input int s, input int p, input int h, input int mid_c,
                         input logic [3:0] mid_req, input int fixed);
    int         len, k;
    logic [1:0] win;
    logic       rdb, inp, coincide;
    logic [3:0] rw_base, gexp;
    len     = s + p + h;
    win     = model_pick(req_v);
    rdb     = rw_v[win];
    rw_base = rw_v;
    gexp    = 4'b0001 << win;
    for (int c = 0; c <= 2 * len + 1; c++) begin
      @(negedge clk);
      k   = c % len;
      inp = (c < 2 * len) && (k >= s) && (k < s + p);
      check("grant", 8'(ob.grant), (c <= 2 * len) ? 8'(gexp) : 8'h00);
      if (c <= 2 * len) check("data_sel", 8'(ob.data_sel), 8'(win));
      check("addr_phase", 8'(ob.addr_phase), 8'(c < len));
      check("bus_oe", 8'(ob.bus_oe), 8'((c < len) || (c < 2 * len && !rdb)));
      check("cs_n", 8'(ob.cs_n), 8'(c >= 2 * len));
      check("ad_n", 8'(ob.ad_n), 8'(c >= len));
      check("wr_n", 8'(ob.wr_n), 8'(!(inp && (c < len || !rdb))));
      check("rd_n", 8'(ob.rd_n), 8'(!(inp && c >= len && rdb)));
      check("done", 8'(ob.done), 8'(c == 2 * len));
      check("rd_data", ob.rd_data, exp_rd);
      coincide = ((ob.wr_n != prev_wr) || (ob.rd_n != prev_rd)) &&
                 ((ob.cs_n != prev_cs) || (ob.ad_n != prev_ad));
      check("strobe_edge_order", 8'(coincide), 8'h00);
      prev_cs = ob.cs_n; prev_ad = ob.ad_n; prev_wr = ob.wr_n; prev_rd = ob.rd_n;
      if (fixed >= 0 && c >= len + s && c < len + s + p) bus_in = fixed[7:0];
      else bus_in = 8'($urandom);
      if (rdb && c == len + s + p - 1) exp_rd = bus_in;
      if (c == mid_c) req_v = mid_req;
      rw_v = (c < 2 * len) ? 4'($urandom) : rw_base;
      if (c == 2 * len) req_v[win] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sel_dut = 1'b0; req_v = 4'b0; rw_v = 4'b0; bus_in = 8'h00;
    exp_rd = 8'h00;
    prev_cs = 1'b1; prev_ad = 1'b1; prev_wr = 1'b1; prev_rd = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);

    // WI write with default timing.
    req_v = 4'b0001; rw_v = 4'b0000;
    run_txn(2, 6, 2, 1, 4'b0000, -1);

    // Periodic read returning 5A.
    req_v = 4'b0100; rw_v = 4'b0100;
    run_txn(2, 6, 2, 1, 4'b0000, 8'h5A);
    check("rd_5a", ob.rd_data, 8'h5A);

    // Simultaneous WF, I, WR: served WF, WR, I back to back.
    req_v = 4'b1110; rw_v = 4'($urandom);
    run_txn(2, 6, 2, -1, 4'b0000, -1);
    run_txn(2, 6, 2, -1, 4'b0000, -1);
    run_txn(2, 6, 2, -1, 4'b0000, -1);

    // I in progress, WI arrives mid-transaction and waits.
    req_v = 4'b0100; rw_v = 4'($urandom);
    run_txn(2, 6, 2, 5, 4'b0101, -1);
    run_txn(2, 6, 2, -1, 4'b0000, -1);

    // Reset during the data-phase write pulse.
    req_v = 4'b0001; rw_v = 4'b0000;
    repeat (15) @(negedge clk);
    req_v = 4'b0000;
    check("pre_reset_wr_n", 8'(ob.wr_n), 8'h00);
    #2 reset = 1'b1;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0; exp_rd = 8'h00;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("post_reset_done", 8'(ob.done), 8'h00);
      check("post_reset_grant", 8'(ob.grant), 8'h00);
    end
    req_v = 4'b1000; rw_v = 4'($urandom);
    run_txn(2, 6, 2, -1, 4'b0000, -1);

    // Random request mixes, default timing.
    for (int i = 0; i < 6; i++) begin
      req_v = 4'($urandom_range(1, 15)); rw_v = 4'($urandom);
      while (req_v != 4'b0000) run_txn(2, 6, 2, -1, 4'b0000, -1);
    end

    // Minimum timing instance.
    sel_dut = 1'b1;
    pulse_reset("min_reset");
    req_v = 4'b0001; rw_v = 4'b0000;
    run_txn(1, 1, 1, 1, 4'b0000, -1);
    req_v = 4'b0100; rw_v = 4'b0100;
    run_txn(1, 1, 1, 1, 4'b0000, -1);
    for (int i = 0; i < 6; i++) begin
      req_v = 4'($urandom_range(1, 15)); rw_v = 4'($urandom);
      while (req_v != 4'b0000) run_txn(1, 1, 1, -1, 4'b0000, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
